// File: rtl/alu_hilo_if.sv
// EX-stage ALU bus: operation, operands and shift amount in; result, flags and
// divider status out. The pipeline side drives through master, the ALU through slave.
interface alu_hilo_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       ALUOperation;
    logic             ex_valid;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             div_busy;
    logic             stall;

    modport master (
        output ALUOperation, ex_valid, src_a, src_b, shamt,
        input  result, zero, div_busy, stall
    );

    modport slave (
        input  ALUOperation, ex_valid, src_a, src_b, shamt,
        output result, zero, div_busy, stall
    );
endinterface

// File: rtl/alu_hilo.sv
// Execution-stage ALU: single-cycle add/sub/and/or/slt/sll, plus a WIDTH-cycle
// restoring unsigned divider that writes HI/LO and a stall toward the hazard unit.
module alu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    alu_hilo_if.slave bus
);
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_MFHI = 6'b010000;
    localparam logic [5:0] OP_MFLO = 6'b010010;
    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    typedef enum logic {IDLE, DIV} state_t;

    state_t           state;
    logic             busy;
    logic [5:0]       cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             is_divu;
    logic             uses_hilo;
    logic             issue;

    assign is_divu   = (bus.ALUOperation == OP_DIVU);
    assign uses_hilo = is_divu || (bus.ALUOperation == OP_MFHI) || (bus.ALUOperation == OP_MFLO);
    assign issue     = (state == IDLE) && bus.ex_valid && is_divu;

    assign bus.stall    = busy && bus.ex_valid && uses_hilo;
    assign bus.div_busy = busy;
    assign bus.zero     = (bus.result == '0);

    // One restoring step: shift in the next dividend bit, keep the difference if it
    // did not go negative. Subtracting in WIDTH+2 bits makes the top bit a true sign.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {2'b00, dvs};
        rem_next = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], ~diff[WIDTH+1]};
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        bus.result = '0;
        case (bus.ALUOperation)
            OP_ADD:  bus.result = bus.src_a + bus.src_b;
            OP_SUB:  bus.result = bus.src_a - bus.src_b;
            OP_AND:  bus.result = bus.src_a & bus.src_b;
            OP_OR:   bus.result = bus.src_a | bus.src_b;
            OP_SLT:  bus.result = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            OP_SLL:  bus.result = bus.src_b << bus.shamt;
            OP_MFHI: bus.result = hi;
            OP_MFLO: bus.result = lo;
            default: bus.result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        quo   <= bus.src_a;
                        dvs   <= bus.src_b;
                        rem   <= '0;
                        cnt   <= '0;
                        state <= DIV;
                        busy  <= 1'b1;
                    end
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 6'd1;
                    // HI/LO are written only when the final step completes.
                    if (cnt == LAST_STEP) begin
                        hi    <= rem_next[WIDTH-1:0];
                        lo    <= quo_next;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_hilo.sv
// Randomized self-checking bench for alu_hilo: a cycle-level model built on plain
// arithmetic (/, %, signed compare) is compared every cycle, plus directed literals.
module tb_alu_hilo;
    localparam int W = 32;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_DIVU = 6'b011011;
    localparam logic [5:0] OP_MFHI = 6'b010000;
    localparam logic [5:0] OP_MFLO = 6'b010010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_hilo_if #(.WIDTH(W)) bus ();

    alu_hilo #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: divider is "busy for W edges after issue", then HI/LO = a % b, a / b.
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    int           m_left = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    bit           chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                if (m_b == 0) begin
                    m_lo = '1; m_hi = m_a;
                end else begin
                    m_lo = m_a / m_b; m_hi = m_a % m_b;
                end
            end
        end else if (bus.ex_valid && bus.ALUOperation == OP_DIVU) begin
            m_a = bus.src_a; m_b = bus.src_b; m_left = W;
        end
    end

    function automatic logic [W-1:0] exp_result();
        case (bus.ALUOperation)
            OP_ADD:  return bus.src_a + bus.src_b;
            OP_SUB:  return bus.src_a - bus.src_b;
            OP_AND:  return bus.src_a & bus.src_b;
            OP_OR:   return bus.src_a | bus.src_b;
            OP_SLT:  return ($signed(bus.src_a) < $signed(bus.src_b)) ? 1 : 0;
            OP_SLL:  return bus.src_b << bus.shamt;
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [W-1:0] er;
            logic         eb;
            logic         es;
            er = exp_result();
            eb = (m_left > 0);
            es = eb && bus.ex_valid &&
                 (bus.ALUOperation inside {OP_DIVU, OP_MFHI, OP_MFLO});
            check("m_result", bus.result, er);
            check("m_zero", W'(bus.zero), W'(er == '0));
            check("m_busy", W'(bus.div_busy), W'(eb));
            check("m_stall", W'(bus.stall), W'(es));
        end
    end

    task automatic set_in(input logic [5:0] op, input logic v, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh);
        bus.ALUOperation = op;
        bus.ex_valid     = v;
        bus.src_a        = a;
        bus.src_b        = b;
        bus.shamt        = sh;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stalled cycles with the current inputs held; leaves time at the first
    // unstalled negedge. Bounded so a stuck stall shows up as a wrong count.
    task automatic count_stalls(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.stall) break;
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        set_in(OP_MFHI, 1'b1, '0, '0, '0);
        tick();
        tick();
        chk_en = 1;
        @(negedge clk);
        check("rst_result", bus.result, 32'h0);
        check("rst_busy", W'(bus.div_busy), 32'h0);
        check("rst_stall", W'(bus.stall), 32'h0);
        tick();
        rst = 1'b0;

        set_in(OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, '0);
        @(negedge clk);
        check("add_ovf", bus.result, 32'h8000_0000);
        check("add_zero", W'(bus.zero), 32'h0);
        tick();
        set_in(OP_SUB, 1'b1, 32'd5, 32'd5, '0);
        @(negedge clk);
        check("sub_res", bus.result, 32'h0);
        check("sub_zero", W'(bus.zero), 32'h1);
        tick();
        set_in(OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1, '0);
        @(negedge clk);
        check("slt_neg", bus.result, 32'h1);
        tick();
        set_in(OP_SLL, 1'b1, '0, 32'h1, 5'd31);
        @(negedge clk);
        check("sll_31", bus.result, 32'h8000_0000);
        tick();
        set_in(6'b000010, 1'b1, 32'h1, 32'h1, '0);
        @(negedge clk);
        check("undef_op", bus.result, 32'h0);
        tick();

        // divu 100/7 with mflo held behind it
        set_in(OP_DIVU, 1'b1, 32'd100, 32'd7, '0);
        @(negedge clk);
        check("divu_idle_stall", W'(bus.stall), 32'h0);
        tick();
        set_in(OP_MFLO, 1'b1, '0, '0, '0);
        count_stalls(n);
        check("mflo_stall_cycles", 32'(n), 32'd32);
        check("mflo_100_7", bus.result, 32'd14);
        tick();
        set_in(OP_MFHI, 1'b1, '0, '0, '0);
        @(negedge clk);
        check("mfhi_100_7", bus.result, 32'd2);
        tick();

        // divide by zero
        set_in(OP_DIVU, 1'b1, 32'h1234_5678, 32'h0, '0);
        tick();
        set_in(OP_MFLO, 1'b1, '0, '0, '0);
        count_stalls(n);
        check("div0_lo", bus.result, 32'hFFFF_FFFF);
        tick();
        set_in(OP_MFHI, 1'b1, '0, '0, '0);
        @(negedge clk);
        check("div0_hi", bus.result, 32'h1234_5678);
        tick();

        // back-to-back divu: second stalls 32 cycles, then issues at E33
        set_in(OP_DIVU, 1'b1, 32'd9, 32'd2, '0);
        tick();
        set_in(OP_DIVU, 1'b1, 32'd1000, 32'd10, '0);
        count_stalls(n);
        check("b2b_stall_cycles", 32'(n), 32'd32);
        tick();
        set_in(OP_MFLO, 1'b1, '0, '0, '0);
        @(negedge clk);
        check("b2b_issued", W'(bus.div_busy), 32'h1);
        count_stalls(n);
        check("b2b_lo", bus.result, 32'd100);
        tick();

        // reset at cycle 10 of a divide
        set_in(OP_DIVU, 1'b1, 32'd50, 32'd3, '0);
        tick();
        set_in(OP_ADD, 1'b0, '0, '0, '0);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(OP_MFHI, 1'b1, '0, '0, '0);
        @(negedge clk);
        check("rst_mid_busy", W'(bus.div_busy), 32'h0);
        check("rst_mid_hi", bus.result, 32'h0);
        check("rst_mid_stall", W'(bus.stall), 32'h0);
        tick();
        set_in(OP_MFLO, 1'b1, '0, '0, '0);
        @(negedge clk);
        check("rst_mid_lo", bus.result, 32'h0);
        tick();

        // independent ops during DIV, then ex_valid=0 divu
        set_in(OP_DIVU, 1'b1, 32'd77, 32'd5, '0);
        tick();
        set_in(OP_OR, 1'b1, 32'hF0, 32'h0F, '0);
        @(negedge clk);
        check("or_during_div", bus.result, 32'hFF);
        check("or_no_stall", W'(bus.stall), 32'h0);
        check("or_busy", W'(bus.div_busy), 32'h1);
        tick();
        set_in(OP_DIVU, 1'b0, 32'd1, 32'd1, '0);
        @(negedge clk);
        check("invalid_no_stall", W'(bus.stall), 32'h0);
        for (int i = 0; i < 40 && bus.div_busy; i++) tick();
        tick();
        @(negedge clk);
        check("invalid_no_issue", W'(bus.div_busy), 32'h0);
        tick();

        // randomized phase; the compare process checks every cycle
        for (int c = 0; c < 3000; c++) begin
            logic [5:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            case ($urandom_range(0, 10))
                0: op = OP_ADD;  1: op = OP_SUB;  2: op = OP_AND;
                3: op = OP_OR;   4: op = OP_SLT;  5: op = OP_SLL;
                6: op = OP_DIVU; 7: op = OP_MFHI; 8: op = OP_MFLO;
                9: op = OP_DIVU;
                default: op = 6'($urandom);
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: b = 32'($urandom_range(0, 65535));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 3));
            set_in(op, ($urandom_range(0, 6) != 0), a, b, 5'($urandom));
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_hilo.md
# alu_hilo

Execution-stage ALU for the pipeline CPU. It consumes the 6-bit `ALUOperation` code produced by `alu_ctl` and computes single-cycle results for add, sub, and, or, slt and sll. It also contains a multicycle unsigned divider that writes the HI/LO register pair, and serves mfhi/mflo from that pair. It sits in EX, between the ID/EX and EX/MEM pipeline registers, and asserts a stall toward the hazard unit when a HI/LO consumer or a new divide meets a divide in progress.

## Interface
- `WIDTH`, 32, datapath width; the divider iteration count equals `WIDTH`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ALUOperation`  in  6  operation code: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll, 011011 divu, 010000 mfhi, 010010 mflo.
- `ex_valid`  in  1  EX stage holds a real instruction; when low, no divu is issued and no stall is raised.
- `src_a`  in  WIDTH  operand A (rs); the dividend for divu.
- `src_b`  in  WIDTH  operand B (rt); the divisor for divu and the shift source for sll.
- `shamt`  in  5  shift amount for sll.
- `result`  out  WIDTH  combinational result.
- `zero`  out  1  high when `result == 0`.
- `div_busy`  out  1  divider iterating; registered.
- `stall`  out  1  hold the IF, ID and EX stages this cycle; combinational.

## Operation
- Combinational ops, all results modulo 2^WIDTH:
  - add: a+b.
  - sub: a−b.
  - and: a&b.
  - or: a|b.
  - slt: signed compare, result 1 or 0.
  - sll: b << shamt.
  - mfhi: HI.
  - mflo: LO.
  - divu: 0.
  - Any undefined code: result 0.
- States: IDLE (`div_busy`=0) and DIV (`div_busy`=1).
- Issue: in IDLE, when `ex_valid` is high and the op is divu, the divider captures `src_a` as the dividend and `src_b` as the divisor, clears its partial remainder and counter, and moves to DIV.
- DIV: performs one restoring-division step per cycle on internal registers (remainder of WIDTH+1 bits, quotient, divisor, counter of 6 bits).
  - After step WIDTH: LO ← quotient, HI ← remainder, state → IDLE.
  - HI/LO never change at any other time.
- Divide by zero requires no special handling; it yields LO = all ones and HI = dividend.
- `stall` = `div_busy` & `ex_valid` & (op ∈ {divu, mfhi, mflo}).
  - A stalled divu does not issue.
  - Other ops proceed while the divider runs.
- Reset: HI=0, LO=0, state IDLE, `div_busy`=0, counter=0. `result`, `zero` and `stall` follow their inputs combinationally.
- Reset asserted during DIV aborts the division; HI and LO go to 0, not to partial results.

## Timing
- Combinational ops have zero latency; `result` is valid in the same cycle.
- Divu sampled at edge E0:
  - `div_busy` is high from after E0 through edge E(WIDTH).
  - HI/LO are written at E(WIDTH), and `div_busy` falls after the same edge.
  - For WIDTH=32, the first cycle in which a following mfhi/mflo can execute unstalled is cycle 33 after the issue cycle. It returns the new value.
- An mfhi/mflo or divu held in EX during DIV stalls every cycle up to and including the E(WIDTH) cycle.
  - It executes or issues in the following cycle.
  - A back-to-back divu issues at E(WIDTH+1).
- `ex_valid` low during DIV: no stall; the division continues.
- Operands captured at E0 are independent of later `src_a`/`src_b` changes.

## Test plan
- add 0x7FFFFFFF+1 → result 0x80000000, zero 0; sub 5−5 → result 0, zero 1.
- slt: a=0xFFFFFFFF (−1), b=1 → result 1; sll b=0x1, shamt=31 → 0x80000000.
- divu 100/7 issued at E0, then mflo held in EX:
  - `stall` high for 32 cycles.
  - Next cycle result 14; mfhi then returns 2.
- divu 0x12345678/0 → LO=0xFFFFFFFF, HI=0x12345678; a second divu presented during busy stalls and issues at E33.
- `rst` pulsed at cycle 10 of a divide → `div_busy` 0, HI=LO=0 next cycle; a later mfhi returns 0 with no stall.
- Independent ops during DIV (e.g. or 0xF0|0x0F → 0xFF) never stall; `ex_valid`=0 with divu present causes no issue and `div_busy` stays 0.
